// File: rtl/any1_lane_align_if.sv
// Request and bus-side signal bundle for any1_lane_align.
// The slave modport is the alignment unit; the master modport is whoever drives requests and answers beats.
interface any1_lane_align_if #(
    parameter int BUS_BYTES = 32,
    parameter int ADDR_W    = 32
);
    logic                   req_valid;
    logic                   req_ready;
    logic                   req_we;
    logic [2:0]             req_sz;
    logic                   req_sgn;
    logic [ADDR_W-1:0]      req_adr;
    logic [BUS_BYTES*8-1:0] req_dat;

    logic                   cyc_o;
    logic                   stb_o;
    logic                   we_o;
    logic [ADDR_W-1:0]      adr_o;
    logic [BUS_BYTES-1:0]   sel_o;
    logic [BUS_BYTES*8-1:0] dat_o;
    logic                   ack_i;
    logic [BUS_BYTES*8-1:0] dat_i;

    logic                   resp_valid;
    logic                   resp_err;
    logic [BUS_BYTES*8-1:0] resp_dat;

    modport slave (
        input  req_valid, req_we, req_sz, req_sgn, req_adr, req_dat, ack_i, dat_i,
        output req_ready, cyc_o, stb_o, we_o, adr_o, sel_o, dat_o,
               resp_valid, resp_err, resp_dat
    );

    modport master (
        output req_valid, req_we, req_sz, req_sgn, req_adr, req_dat, ack_i, dat_i,
        input  req_ready, cyc_o, stb_o, we_o, adr_o, sel_o, dat_o,
               resp_valid, resp_err, resp_dat
    );
endinterface

// File: rtl/any1_lane_align.sv
// Byte-lane select/alignment unit between ANY-1 load/store and the data bus.
// Define ANY1_LANE_SPLIT_EN to let line-crossing accesses run as two beats; otherwise they are rejected.

// One byte lane: masks store data to the access size and fills load bytes above it.
module any1_lane_byte #(
    parameter int IDX = 0
) (
    input  logic [7:0] st_nb,
    input  logic [7:0] ld_nb,
    input  logic [7:0] st_in,
    input  logic [7:0] ld_in,
    input  logic       fill,
    output logic [7:0] st_out,
    output logic [7:0] ld_out
);
    logic st_live, ld_live;

    assign st_live = st_nb > 8'(IDX);
    assign ld_live = ld_nb > 8'(IDX);
    assign st_out  = st_live ? st_in : 8'h00;
    assign ld_out  = ld_live ? ld_in : {8{fill}};
endmodule

module any1_lane_align #(
    parameter int BUS_BYTES = 32,
    parameter int ADDR_W    = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    any1_lane_align_if.slave bus
);
    localparam int LG = $clog2(BUS_BYTES);
    localparam int DW = BUS_BYTES * 8;

    typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, DONE} state_t;

    state_t                 state;
    logic [LG-1:0]          off_r;
    logic [7:0]             nb_r;
    logic                   sgn_r;
    logic                   we_r;

    logic [LG-1:0]          off;
    logic [7:0]             nbytes;
    logic                   oversize;
    logic                   split;
    logic                   reject;
    logic [2*BUS_BYTES-1:0] wide;
    logic [BUS_BYTES-1:0]   sel0;
    logic [ADDR_W-1:0]      adr0;
    logic [DW-1:0]          sdat_m;
    logic [DW-1:0]          sdat0;
    logic [DW-1:0]          ld_sh;
    logic [DW-1:0]          ld_ext;
    logic                   fill;
    logic                   last_beat;

    // request decode, valid only while in IDLE
    assign off      = bus.req_adr[LG-1:0];
    assign nbytes   = 8'd1 << bus.req_sz;
    assign oversize = nbytes > 8'(BUS_BYTES);
    assign adr0     = {bus.req_adr[ADDR_W-1:LG], {LG{1'b0}}};

    always_comb begin
        wide = '0;
        for (int j = 0; j < 2*BUS_BYTES; j++)
            wide[j] = (j >= int'(off)) && (j < int'(off) + int'(nbytes));
    end

    assign sel0  = wide[BUS_BYTES-1:0];
    assign split = |wide[2*BUS_BYTES-1:BUS_BYTES];

`ifdef ANY1_LANE_SPLIT_EN
    logic [ADDR_W-1:0]    adr1, adr1_r;
    logic [BUS_BYTES-1:0] sel1_r;
    logic [DW-1:0]        sdat1, dat1_r, rd0_r;
    logic [2*DW-1:0]      sdat_w;
    logic                 split_r;

    assign reject    = oversize;
    assign adr1      = adr0 + ADDR_W'(BUS_BYTES);
    assign sdat_w    = {{DW{1'b0}}, sdat_m} << {off, 3'b000};
    assign sdat0     = sdat_w[DW-1:0];
    assign sdat1     = sdat_w[2*DW-1:DW];
    assign last_beat = (state == BEAT1) || !split_r;

    // beat 0 data sits in rd0_r once beat 1 is on the bus
    always_comb begin
        if (state == BEAT1)
            ld_sh = DW'({bus.dat_i, rd0_r} >> {off_r, 3'b000});
        else
            ld_sh = bus.dat_i >> {off_r, 3'b000};
    end
`else
    assign reject    = oversize || split;
    assign sdat0     = sdat_m << {off, 3'b000};
    assign last_beat = 1'b1;
    assign ld_sh     = bus.dat_i >> {off_r, 3'b000};
`endif

    // sign source is the top byte actually loaded
    always_comb begin
        fill = 1'b0;
        for (int i = 0; i < BUS_BYTES; i++)
            if (i == int'(nb_r) - 1)
                fill = sgn_r & ld_sh[8*i+7];
    end

    genvar g;
    generate
        for (g = 0; g < BUS_BYTES; g++) begin : g_lane
            any1_lane_byte #(.IDX(g)) u_lane (
                .st_nb  (nbytes),
                .ld_nb  (nb_r),
                .st_in  (bus.req_dat[8*g +: 8]),
                .ld_in  (ld_sh[8*g +: 8]),
                .fill   (fill),
                .st_out (sdat_m[8*g +: 8]),
                .ld_out (ld_ext[8*g +: 8])
            );
        end
    endgenerate

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state          <= IDLE;
            off_r          <= '0;
            nb_r           <= '0;
            sgn_r          <= 1'b0;
            we_r           <= 1'b0;
            bus.req_ready  <= 1'b1;
            bus.cyc_o      <= 1'b0;
            bus.stb_o      <= 1'b0;
            bus.we_o       <= 1'b0;
            bus.adr_o      <= '0;
            bus.sel_o      <= '0;
            bus.dat_o      <= '0;
            bus.resp_valid <= 1'b0;
            bus.resp_err   <= 1'b0;
            bus.resp_dat   <= '0;
`ifdef ANY1_LANE_SPLIT_EN
            split_r        <= 1'b0;
            adr1_r         <= '0;
            sel1_r         <= '0;
            dat1_r         <= '0;
            rd0_r          <= '0;
`endif
        end else begin
            bus.resp_valid <= 1'b0;
            bus.resp_err   <= 1'b0;
            bus.resp_dat   <= '0;
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        bus.req_ready <= 1'b0;
                        off_r         <= off;
                        nb_r          <= nbytes;
                        sgn_r         <= bus.req_sgn;
                        we_r          <= bus.req_we;
`ifdef ANY1_LANE_SPLIT_EN
                        split_r       <= split;
                        adr1_r        <= adr1;
                        sel1_r        <= wide[2*BUS_BYTES-1:BUS_BYTES];
                        dat1_r        <= bus.req_we ? sdat1 : '0;
`endif
                        if (reject) begin
                            state          <= DONE;
                            bus.resp_valid <= 1'b1;
                            bus.resp_err   <= 1'b1;
                        end else begin
                            state     <= BEAT0;
                            bus.cyc_o <= 1'b1;
                            bus.stb_o <= 1'b1;
                            bus.we_o  <= bus.req_we;
                            bus.adr_o <= adr0;
                            bus.sel_o <= sel0;
                            bus.dat_o <= bus.req_we ? sdat0 : '0;
                        end
                    end
                end
                BEAT0, BEAT1: begin
                    if (bus.ack_i) begin
                        if (last_beat) begin
                            state          <= DONE;
                            bus.cyc_o      <= 1'b0;
                            bus.stb_o      <= 1'b0;
                            bus.we_o       <= 1'b0;
                            bus.adr_o      <= '0;
                            bus.sel_o      <= '0;
                            bus.dat_o      <= '0;
                            bus.resp_valid <= 1'b1;
                            bus.resp_dat   <= we_r ? '0 : ld_ext;
                        end
`ifdef ANY1_LANE_SPLIT_EN
                        else begin
                            // cyc_o/stb_o/we_o stay up across the beat change
                            state     <= BEAT1;
                            rd0_r     <= bus.dat_i;
                            bus.adr_o <= adr1_r;
                            bus.sel_o <= sel1_r;
                            bus.dat_o <= dat1_r;
                        end
`endif
                    end
                end
                DONE: begin
                    state         <= IDLE;
                    bus.req_ready <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_any1_lane_align.sv
// Randomised scoreboard bench for any1_lane_align (BUS_BYTES=32, ADDR_W=32).
// A byte-level model predicts beats and responses; a bus responder and a response monitor check them.
module tb_any1_lane_align;
    localparam int BB = 32;
    localparam int DW = BB * 8;
`ifdef ANY1_LANE_SPLIT_EN
    localparam bit SPLIT = 1'b1;
`else
    localparam bit SPLIT = 1'b0;
`endif

    typedef struct {
        logic [31:0]   adr;
        logic [BB-1:0] sel;
        logic [DW-1:0] wdat;
        bit            we;
        logic [DW-1:0] rdat;
        int            dly;   // -1 random, -2 never ack, else fixed wait
    } beat_t;

    typedef struct {
        bit            err;
        logic [DW-1:0] dat;
    } resp_t;

    logic  clk = 1'b0;
    logic  rst_i = 1'b1;
    beat_t bq[$];
    resp_t rq[$];
    int    vec = 0;
    int    errs = 0;

    any1_lane_align_if #(.BUS_BYTES(BB), .ADDR_W(32)) bus ();

    any1_lane_align #(.BUS_BYTES(BB), .ADDR_W(32)) dut (
        .clk_i (clk),
        .rst_i (rst_i),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        vec++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] rand_w();
        logic [DW-1:0] r;
        for (int i = 0; i < DW/32; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    // Byte-wise reference: access byte k lives at line offset off+k, in beat 0 or beat 1.
    task automatic plan(input bit we, input int sz, input bit sgn, input logic [31:0] adr,
                        input logic [DW-1:0] wd, input logic [DW-1:0] r0, input logic [DW-1:0] r1,
                        input bit fixed, input bit hang, output bit err, output bit spl);
        int off, n, lane, pos;
        beat_t b;
        resp_t r;
        logic [7:0] byt;
        bit neg;
        off = int'(adr % BB);
        n   = 1 << sz;
        spl = (off + n) > BB;
        err = (n > BB) || (spl && !SPLIT);
        r.err = err;
        r.dat = '0;
        if (!err) begin
            for (int bi = 0; bi < (spl ? 2 : 1); bi++) begin
                b.adr  = (adr - 32'(off)) + 32'(bi * BB);
                b.sel  = '0;
                b.wdat = '0;
                b.we   = we;
                b.rdat = (bi == 1) ? r1 : r0;
                b.dly  = (hang && bi == 1) ? -2 : (fixed ? 0 : -1);
                for (int k = 0; k < n; k++) begin
                    lane = off + k - bi * BB;
                    if (lane >= 0 && lane < BB) begin
                        b.sel[lane]         = 1'b1;
                        b.wdat[8*lane +: 8] = wd[8*k +: 8];
                    end
                end
                bq.push_back(b);
            end
            if (!we) begin
                neg = 1'b0;
                for (int k = 0; k < n; k++) begin
                    pos = off + k;
                    byt = (pos < BB) ? r0[8*pos +: 8] : r1[8*(pos-BB) +: 8];
                    r.dat[8*k +: 8] = byt;
                    neg = byt[7];
                end
                if (sgn && neg)
                    for (int k = n; k < BB; k++) r.dat[8*k +: 8] = 8'hFF;
            end
        end
        if (!hang) rq.push_back(r);
    endtask

    task automatic issue(input bit we, input int sz, input bit sgn, input logic [31:0] adr,
                         input logic [DW-1:0] wd, input logic [DW-1:0] r0, input logic [DW-1:0] r1,
                         input bit fixed, input bit hang);
        bit err, spl;
        int lat, n;
        plan(we, sz, sgn, adr, wd, r0, r1, fixed, hang, err, spl);
        n = 0;
        while (!bus.req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!bus.req_ready) chk("ready_timeout", bus.req_ready, 1);
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_sz    = 3'(sz);
        bus.req_sgn   = sgn;
        bus.req_adr   = adr;
        bus.req_dat   = wd;
        @(negedge clk);
        bus.req_valid = 1'b0;
        chk("ready_busy", bus.req_ready, 0);
        if (hang) return;
        lat = 1;
        while (!bus.resp_valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        if (fixed) chk("latency", lat, err ? 1 : (spl ? 3 : 2));
        else if (!bus.resp_valid) chk("resp_timeout", bus.resp_valid, 1);
        @(negedge clk);
    endtask

    // response monitor
    initial begin : mon
        resp_t r;
        forever begin
            @(negedge clk);
            if (bus.resp_valid) begin
                if (rq.size() == 0) chk("resp_unexpected", bus.resp_valid, 0);
                else begin
                    r = rq.pop_front();
                    chk("resp_err", bus.resp_err, r.err);
                    chk("resp_dat", bus.resp_dat, r.dat);
                end
            end
        end
    end

    // bus responder: checks each beat on arrival, acks after its delay, pokes stray acks when idle
    initial begin : bfm
        beat_t b;
        bit    inbeat;
        int    wcnt;
        inbeat     = 1'b0;
        wcnt       = 0;
        b.dly      = 0;
        b.rdat     = '0;
        bus.ack_i  = 1'b0;
        bus.dat_i  = '0;
        forever begin
            @(negedge clk);
            if (bus.stb_o === 1'b1) begin
                if (!inbeat) begin
                    inbeat = 1'b1;
                    if (bq.size() == 0) begin
                        chk("beat_unexpected", bus.stb_o, 0);
                        b.dly  = 0;
                        b.rdat = '0;
                    end else begin
                        b = bq.pop_front();
                        chk("beat_adr", bus.adr_o, b.adr);
                        chk("beat_sel", bus.sel_o, b.sel);
                        chk("beat_we", bus.we_o, b.we);
                        chk("beat_cyc", bus.cyc_o, 1);
                        if (b.we) chk("beat_dat", bus.dat_o, b.wdat);
                    end
                    wcnt = (b.dly == -1) ? int'($urandom_range(0, 2)) : b.dly;
                end
                if (wcnt == 0) begin
                    bus.ack_i = 1'b1;
                    bus.dat_i = b.rdat;
                    inbeat    = 1'b0;
                end else begin
                    bus.ack_i = 1'b0;
                    bus.dat_i = rand_w();
                    if (wcnt > 0) wcnt--;
                end
            end else begin
                inbeat    = 1'b0;
                bus.ack_i = ($urandom_range(0, 7) == 0);
                bus.dat_i = rand_w();
                if (!rst_i) begin
                    chk("idle_bus", {bus.cyc_o, bus.we_o, bus.adr_o, bus.sel_o}, '0);
                    chk("idle_dat", bus.dat_o, '0);
                end
            end
        end
    end

    initial begin : stim
        logic [DW-1:0] wd, r0, r1;
        logic [31:0]   adr;
        int            n;
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_sz    = '0;
        bus.req_sgn   = 1'b0;
        bus.req_adr   = '0;
        bus.req_dat   = '0;
        repeat (3) @(negedge clk);
        rst_i = 1'b0;
        @(negedge clk);
        chk("rst_ready", bus.req_ready, 1);
        chk("rst_cyc", bus.cyc_o, 0);
        chk("rst_stb", bus.stb_o, 0);
        chk("rst_we", bus.we_o, 0);
        chk("rst_adr", bus.adr_o, 0);
        chk("rst_sel", bus.sel_o, 0);
        chk("rst_dat", bus.dat_o, 0);
        chk("rst_rv", bus.resp_valid, 0);
        chk("rst_re", bus.resp_err, 0);
        chk("rst_rd", bus.resp_dat, 0);

        // byte load, unsigned
        r0 = rand_w();
        r0[47:40] = 8'h9A;
        issue(1'b0, 0, 1'b0, 32'h1005, rand_w(), r0, rand_w(), 1'b1, 1'b0);
        // 8-byte store crossing the line
        wd = rand_w();
        wd[63:0] = 64'h1122334455667788;
        issue(1'b1, 3, 1'b0, 32'h101C, wd, rand_w(), rand_w(), 1'b1, 1'b0);
        // signed halfword across the line
        r0 = rand_w();
        r1 = rand_w();
        r0[255:248] = 8'h80;
        r1[7:0]     = 8'hFF;
        issue(1'b0, 1, 1'b1, 32'h101F, rand_w(), r0, r1, 1'b1, 1'b0);
        // oversize, then a word crossing the line
        issue(1'b0, 6, 1'b0, 32'h2000, rand_w(), rand_w(), rand_w(), 1'b1, 1'b0);
        issue(1'b0, 2, 1'b0, 32'h101E, rand_w(), rand_w(), rand_w(), 1'b1, 1'b0);
        // full-width aligned signed load
        issue(1'b0, 5, 1'b1, 32'h3000, rand_w(), rand_w(), rand_w(), 1'b1, 1'b0);

`ifdef ANY1_LANE_SPLIT_EN
        // wrap to address 0, reset while beat 1 waits for its ack
        issue(1'b0, 2, 1'b0, 32'hFFFFFFFE, rand_w(), rand_w(), rand_w(), 1'b1, 1'b1);
        n = 0;
        while (!(bus.stb_o && bus.adr_o == 32'h0) && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("wrap_stb", bus.stb_o, 1);
        chk("wrap_sel", bus.sel_o, 32'h3);
        rst_i = 1'b1;
        @(negedge clk);
        rst_i = 1'b0;
        chk("mid_rst_cyc", bus.cyc_o, 0);
        chk("mid_rst_stb", bus.stb_o, 0);
        chk("mid_rst_ready", bus.req_ready, 1);
        chk("mid_rst_rv", bus.resp_valid, 0);
        repeat (3) @(negedge clk);
`endif

        for (int t = 0; t < 300; t++) begin
            adr = $urandom;
            if ($urandom_range(0, 7) == 0) adr = 32'hFFFFFFE0 | 32'($urandom_range(0, 31));
            issue(1'($urandom_range(0, 1)), int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                  adr, rand_w(), rand_w(), rand_w(), 1'b0, 1'b0);
        end

        repeat (5) @(negedge clk);
        chk("resp_left", 32'(rq.size()), 0);
        chk("beat_left", 32'(bq.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end
endmodule
